// File: rtl/lsb_first_serializer.sv
// ============================================================================
// Module      : lsb_first_serializer
// Description : Accepts a parallel word over valid/ready and shifts it out
//               LSB first, preceded by a one-cycle clear pulse for the
//               downstream serial FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_first_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             fsm_clr,
    output logic             last,
    output logic             busy
);

    localparam int               c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_cnt_last;

    assign w_cnt_last = (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_shreg <= load_data;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_shreg <= r_shreg >> 1;
                    // Counter parks at zero after the final bit instead of wrapping.
                    r_cnt   <= w_cnt_last ? '0 : r_cnt + c_cnt_w'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        fsm_clr     = 1'b0;
        last        = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Ready is suppressed during reset so a word is never lost.
                load_ready = ~rst;
                if (load_valid) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                fsm_clr     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = r_shreg[0];
                busy      = 1'b1;
                last      = w_cnt_last;
                if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lsb_first_serializer.sv
// ============================================================================
// Module      : tb_lsb_first_serializer
// Description : Self-checking bench for lsb_first_serializer (WIDTH 8 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsb_first_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready, ser_out, ser_valid, fsm_clr, last, busy;

    logic       rst4 = 1'b1, load_valid4 = 1'b0;
    logic [3:0] load_data4 = '0;
    logic       load_ready4, ser_out4, ser_valid4, fsm_clr4, last4, busy4;

    lsb_first_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .fsm_clr(fsm_clr), .last(last), .busy(busy)
    );

    lsb_first_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .load_valid(load_valid4), .load_data(load_data4),
        .load_ready(load_ready4), .ser_out(ser_out4), .ser_valid(ser_valid4),
        .fsm_clr(fsm_clr4), .last(last4), .busy(busy4)
    );

    int checks = 0;
    int errors = 0;

    // Reference: -1 = idle, 0 = clear cycle, p in 1..8 = bit p-1 on the wire.
    int         m_phase = -1;
    logic [7:0] m_word  = '0;

    int   cyc = 0;
    int   clr_cyc[$];
    logic bits_q[$];
    int   last_at[$];
    logic obs_ready;
    logic obs_valid;

    typedef struct {
        logic [7:0] data;
        logic [7:0] twos;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        clr_cyc.delete();
        bits_q.delete();
        last_at.delete();
    endtask

    // One clock of the 8-bit DUT: drive, compare against the model, advance.
    task automatic step(input logic r, input logic lv, input logic [7:0] d);
        logic [5:0] e, a;
        logic       eb;
        @(negedge clk);
        rst = r; load_valid = lv; load_data = d;
        #1;
        eb = (m_phase >= 1 && m_phase <= 8) ? m_word[m_phase-1] : 1'b0;
        e  = {(m_phase < 0) && !r, m_phase == 0, m_phase >= 1, eb, m_phase == 8, m_phase >= 0};
        a  = {load_ready, fsm_clr, ser_valid, ser_out, last, busy};
        chk("cycle_outputs", 32'(a), 32'(e));
        if (fsm_clr)   clr_cyc.push_back(cyc);
        if (ser_valid) bits_q.push_back(ser_out);
        if (last)      last_at.push_back(bits_q.size());
        obs_ready = load_ready;
        obs_valid = ser_valid;
        @(posedge clk);
        if (r)                m_phase = -1;
        else if (m_phase < 0) begin
            if (lv) begin m_word = d; m_phase = 0; end
        end
        else if (m_phase >= 8) m_phase = -1;
        else                   m_phase++;
        cyc++;
    endtask

    function automatic logic [7:0] word_of(input int base, input int n);
        logic [7:0] w = '0;
        for (int i = 0; i < n; i++)
            if (base + i < bits_q.size()) w[i] = bits_q[base + i];
        return w;
    endfunction

    // Serial two's complement: copy bits through the first 1, invert the rest.
    function automatic logic [7:0] twos_of(input logic [7:0] w, input int n);
        logic [7:0] o = '0;
        logic       seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            o[i] = seen ? ~w[i] : w[i];
            if (w[i]) seen = 1'b1;
        end
        return o;
    endfunction

    logic [5:0] o4[12];

    task automatic step4(input logic r, input logic lv, input logic [3:0] d, input int idx);
        @(negedge clk);
        rst4 = r; load_valid4 = lv; load_data4 = d;
        #1;
        if (idx >= 0) o4[idx] = {load_ready4, fsm_clr4, ser_valid4, ser_out4, last4, busy4};
        @(posedge clk);
    endtask

    initial begin
        vecs[0] = '{8'h2C, 8'hD4};
        vecs[1] = '{8'h80, 8'h80};
        vecs[2] = '{8'hFF, 8'h01};
        vecs[3] = '{8'h01, 8'hFF};
        vecs[4] = '{8'h00, 8'h00};
        vecs[5] = '{8'h55, 8'hAB};

        // Reset state
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("reset_outputs", 32'({load_ready, fsm_clr, ser_valid, ser_out, last, busy}), 32'h20);

        // Single words from the table
        foreach (vecs[v]) begin
            clear_logs();
            step(1'b0, 1'b1, vecs[v].data);
            repeat (10) step(1'b0, 1'b0, 8'h00);
            chk("word_clr_count", 32'(clr_cyc.size()), 32'd1);
            chk("word_bit_count", 32'(bits_q.size()), 32'd8);
            chk("word_bits", 32'(word_of(0, 8)), 32'(vecs[v].data));
            chk("word_last_pos", (last_at.size() == 1) ? 32'(last_at[0]) : 32'hFFFF, 32'd8);
            chk("word_chained_twos", 32'(twos_of(word_of(0, 8), 8)), 32'(vecs[v].twos));
            chk("word_ready_after", 32'(obs_ready), 32'd1);
        end

        // Busy ignore and spacing: load_valid held, data changes while busy
        clear_logs();
        step(1'b0, 1'b1, 8'h2C);
        repeat (10) step(1'b0, 1'b1, 8'h80);
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("spacing_clr_count", 32'(clr_cyc.size()), 32'd2);
        chk("spacing_clr_gap", (clr_cyc.size() == 2) ? 32'(clr_cyc[1] - clr_cyc[0]) : 32'hFFFF, 32'd10);
        chk("spacing_first_word", 32'(word_of(0, 8)), 32'h2C);
        chk("spacing_second_word", 32'(word_of(8, 8)), 32'h80);
        chk("spacing_second_twos", 32'(twos_of(word_of(8, 8), 8)), 32'h80);

        // Reset during bit 3
        clear_logs();
        step(1'b0, 1'b1, 8'hFF);
        repeat (4) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("abort_valid_after", 32'(obs_valid), 32'd0);
        chk("abort_ready_after", 32'(obs_ready), 32'd1);
        chk("abort_no_last", 32'(last_at.size()), 32'd0);
        chk("abort_bits_seen", 32'(bits_q.size()), 32'd4);
        clear_logs();
        step(1'b0, 1'b1, 8'h2C);
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("abort_next_word", 32'(word_of(0, 8)), 32'h2C);
        chk("abort_next_clr", 32'(clr_cyc.size()), 32'd1);

        // rst and load_valid together
        clear_logs();
        step(1'b1, 1'b1, 8'h55);
        repeat (4) step(1'b0, 1'b0, 8'h00);
        chk("simul_no_clr", 32'(clr_cyc.size()), 32'd0);
        chk("simul_no_bits", 32'(bits_q.size()), 32'd0);
        chk("simul_ready", 32'(obs_ready), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++)
            step(($urandom % 40) == 0, ($urandom % 3) != 0, 8'($urandom));

        // WIDTH=4 with load_valid held
        step4(1'b1, 1'b0, 4'h0, -1);
        step4(1'b1, 1'b0, 4'h0, -1);
        for (int j = 0; j < 12; j++) step4(1'b0, 1'b1, 4'b0110, j);
        begin
            int         clrs[$];
            int         lasts[$];
            logic [7:0] w4 = '0;
            int         nb = 0;
            for (int j = 0; j < 12; j++) begin
                if (o4[j][4]) clrs.push_back(j);
                if (o4[j][1]) lasts.push_back(j);
                if (o4[j][3] && j < 6) begin
                    if (nb < 4) w4[nb] = o4[j][2];
                    nb++;
                end
            end
            chk("w4_accept_ready", 32'(o4[0][5]), 32'd1);
            chk("w4_bit_count", 32'(nb), 32'd4);
            chk("w4_bits", 32'(w4), 32'h6);
            chk("w4_chained_twos", 32'(twos_of(w4, 4)), 32'hA);
            chk("w4_clr_count", 32'(clrs.size()), 32'd2);
            chk("w4_period", (clrs.size() == 2) ? 32'(clrs[1] - clrs[0]) : 32'hFFFF, 32'd6);
            chk("w4_last_pos", (lasts.size() >= 1) ? 32'(lasts[0]) : 32'hFFFF, 32'd5);
            chk("w4_last_count", 32'(lasts.size()), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
